wishbone_response_serializer: RTL and testbench

Downstream stage of the wishbone master. It captures each response the master emits as a one-cycle pulse carrying a 32-bit status, address and data word. Responses are queued in a small FIFO and serialized as a byte stream over a valid/ready handshake to the host-side transmitter (UART/FT245 writer). It also provides the master's out_ready back-pressure signal.

---
 rtl/wishbone_response_serializer.sv | 123 ++++++++++++
 tb/tb_wishbone_response_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_response_serializer.sv
// Queues wishbone master responses and serializes each one as a big-endian byte frame over valid/ready.
// Build option RESP_ASCII_HEX_EN: frames go out as 24 uppercase ASCII hex characters plus a trailing LF.
module wishbone_response_serializer #(
  parameter int FIFO_DEPTH = 2,
  parameter int FIFO_AW    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_en,
  input  logic [31:0] in_status,
  input  logic [31:0] in_address,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        overflow
);

`ifdef RESP_ASCII_HEX_EN
  localparam int FRAME_LEN = 25;
  localparam int IDX_W     = 5;
  localparam int SHIFT     = 4;
`else
  localparam int FRAME_LEN = 12;
  localparam int IDX_W     = 4;
  localparam int SHIFT     = 8;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [95:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, do_push, do_pop;

  state_t             state, state_n;
  logic [95:0]        shreg, shreg_n;
  logic [IDX_W-1:0]   idx, idx_n;

  assign full     = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign in_ready = !full;
  assign do_push  = in_en && !full;
  assign do_pop   = (state == IDLE) && (count != '0);
  assign busy     = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {in_status, in_address, in_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      // a pop in the same cycle never frees room for a push already refused by full
      if (in_en && full)
        overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    idx_n      = idx;
    byte_valid = 1'b0;
    case (state)
      IDLE: begin
        if (do_pop) begin
          shreg_n = mem[rd_ptr];
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        byte_valid = 1'b1;
        if (byte_ready) begin
          if (idx == LAST_IDX) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + 1'b1;
            shreg_n = shreg << SHIFT;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef RESP_ASCII_HEX_EN
  logic [3:0] nib;
  logic [7:0] hex_char;
  assign nib      = shreg[95:92];
  assign hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  assign byte_out = (state != SEND) ? 8'h00 : (idx == LAST_IDX) ? 8'h0A : hex_char;
`else
  assign byte_out = (state == SEND) ? shreg[95:88] : 8'h00;
`endif

endmodule

// File: tb/tb_wishbone_response_serializer.sv
// Scoreboard bench for wishbone_response_serializer: expected bytes are queued at push time and popped on each accepted byte.
module tb_wishbone_response_serializer;

`ifdef RESP_ASCII_HEX_EN
  localparam int FRAME_LEN = 25;
`else
  localparam int FRAME_LEN = 12;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_en = 1'b0;
  logic [31:0] in_status = '0, in_address = '0, in_data = '0;
  logic        in_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        busy;
  logic        overflow;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = '0;

  wishbone_response_serializer #(.FIFO_DEPTH(2), .FIFO_AW(1)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_status(in_status),
    .in_address(in_address), .in_data(in_data), .in_ready(in_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [95:0] w);
    logic [3:0] nib;
`ifdef RESP_ASCII_HEX_EN
    for (int i = 0; i < 24; i++) begin
      nib = w[95-4*i -: 4];
      exp_q.push_back(nib < 10 ? 8'h30 + 8'(nib) : 8'h41 + 8'(nib) - 8'd10);
    end
    exp_q.push_back(8'h0A);
`else
    nib = 4'h0;
    for (int i = 0; i < 12; i++) exp_q.push_back(w[95-8*i -: 8]);
`endif
  endtask

  task automatic send_resp(input logic [31:0] st, input logic [31:0] ad,
                           input logic [31:0] da, input bit kept);
    in_status = st; in_address = ad; in_data = da; in_en = 1'b1;
    if (kept) push_exp({st, ad, da});
    tick();
    in_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // monitor: scoreboard compare on accepted bytes, stability check while stalled
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        check("hold", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, prev_byte});
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
        else check("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
      end
      prev_stall <= byte_valid && !byte_ready;
      prev_byte  <= byte_out;
    end
  end

  initial begin
    int  zeros, gaps, n;
    bit  seen, pv;

    // reset state
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_valid", byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_byte_out", byte_out, 0);

    // 1: single response, latency and busy
    byte_ready = 1'b1;
    send_resp(32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF, 1);
    check("lat_n1_valid", byte_valid, 0);
    check("lat_busy", busy, 1);
    tick();
    check("lat_n2_valid", byte_valid, 1);
    check("first_byte", byte_out, 8'h00);
    drain(100);
    tick();
    check("busy_after", busy, 0);
    check("valid_after", byte_valid, 0);

    // 2: back-pressure 1,0,0,1 pattern
    byte_ready = 1'b0;
    send_resp(32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      byte_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      n++;
    end
    check("bp_left", exp_q.size(), 0);
    byte_ready = 1'b0;
    tick(); tick();
    check("bp_idle", busy, 0);

    // 3: overflow with three queued frames, one dropped, gaps of one cycle
    send_resp(32'h0, 32'h0, 32'hA, 1);
    send_resp(32'h0, 32'h0, 32'hB, 1);
    check("ready_after_b", in_ready, 1);
    send_resp(32'h0, 32'h0, 32'hC, 1);
    check("ready_full", in_ready, 0);
    check("ovf_before", overflow, 0);
    send_resp(32'h0, 32'h0, 32'hD, 0);
    check("ovf_set", overflow, 1);
    check("ready_still_full", in_ready, 0);
    byte_ready = 1'b1;
    zeros = 0; gaps = 0; seen = 0; pv = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
      if (!byte_valid) zeros++;
      if (byte_valid && !pv && seen) begin
        check("gap_len", zeros, 1);
        gaps++;
      end
      if (byte_valid) begin seen = 1; zeros = 0; end
      pv = byte_valid;
    end
    check("ovf_left", exp_q.size(), 0);
    check("gap_count", gaps, 2);
    check("ovf_sticky", overflow, 1);

    // 4: push while full coincides with a pop
    do_reset();
    check("ovf_cleared", overflow, 0);
    byte_ready = 1'b0;
    send_resp(32'h1, 32'h2, 32'hE, 1);
    send_resp(32'h1, 32'h2, 32'hF, 1);
    send_resp(32'h1, 32'h2, 32'h10, 1);
    byte_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 2*FRAME_LEN && n < 100) begin tick(); n++; end
    check("pop_cycle_valid", byte_valid, 0);
    check("pop_cycle_full", in_ready, 0);
    send_resp(32'h1, 32'h2, 32'h11, 0);
    check("pp_ovf", overflow, 1);
    check("pp_count_dec", in_ready, 1);
    check("pp_valid", byte_valid, 1);
    drain(200);

    // 5: reset after byte 5 with a frame queued
    do_reset();
    byte_ready = 1'b0;
    send_resp(32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 1);
    send_resp(32'h8888_8888, 32'h9999_9999, 32'hAAAA_AAAA, 1);
    byte_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 2*FRAME_LEN - 5 && n < 100) begin tick(); n++; end
    check("mid_valid", byte_valid, 1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("mr_valid", byte_valid, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_ovf", overflow, 0);
    check("mr_busy", busy, 0);
    rst = 1'b0;
    repeat (40) tick();
    check("mr_quiet", {byte_valid, busy}, 2'b00);

    // 6: hex-friendly pattern, plus a few random frames under random ready
    send_resp(32'h0000_ABCD, 32'h0, 32'h0000_0009, 1);
    drain(100);
    for (int k = 0; k < 3; k++) begin
      byte_ready = 1'b0;
      send_resp($urandom, $urandom, $urandom, 1);
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
        byte_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      check("rnd_left", exp_q.size(), 0);
    end
    byte_ready = 1'b0;
    tick(); tick();
    check("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
